// File: rtl/rate_ctrl_pkg.sv
// Shared encodings for the rate controller: FSM state type and rate-select codes.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package rate_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10,
    ST_STEP = 2'b11
  } state_t;

  // Rate select codes: 00 ticks every cycle, the others pick a divider reload.
  localparam logic [1:0] SEL_EVERY = 2'b00;
  localparam logic [1:0] SEL_DIV1  = 2'b01;
  localparam logic [1:0] SEL_DIV2  = 2'b10;
  localparam logic [1:0] SEL_DIV3  = 2'b11;

endpackage

// File: rtl/rate_downcounter.sv
// Loadable CNT_W-bit down-counter with a zero flag; saturates at 0.
// Latency: load/decrement visible one cycle after the request; zero is combinational from the count.
// Backpressure: none; load has priority over decrement.
// Ports: clock, reset_n (async active-low), load + load_val, dec, zero.
module rate_downcounter #(
  parameter int unsigned CNT_W = 28
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      // Never wrap below zero; the controller reloads at zero instead.
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/rate_controller.sv
// Rate controller: generates a divided tick enable and a clear pulse for a display counter.
// Latency: tick/clr_out are registered, appearing the cycle after the deciding cycle; LOAD costs one cycle.
// Backpressure: none; commands are level-sampled every cycle with priority clear > stop > start > step.
// Ports: clock, reset_n (async active-low); start/stop/step/clear/select commands;
//        tick, clr_out pulses; running, state, active_sel status.
// Build option: define RATE_CTRL_STEP_EN to enable the single-step (STEP state) feature.
module rate_controller
  import rate_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 28,
  parameter int unsigned DIV_1 = 4999999,
  parameter int unsigned DIV_2 = 99999999,
  parameter int unsigned DIV_3 = 199999999
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic       stop,
  input  logic       step,
  input  logic       clear,
  input  logic [1:0] select,
  output logic       tick,
  output logic       clr_out,
  output logic       running,
  output logic [1:0] state,
  output logic [1:0] active_sel
);

  state_t           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic             tick_d, clr_d;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_load_val;
  logic             step_req;

  function automatic logic [CNT_W-1:0] div_of(input logic [1:0] s);
    case (s)
      SEL_DIV1: div_of = CNT_W'(DIV_1);
      SEL_DIV2: div_of = CNT_W'(DIV_2);
      SEL_DIV3: div_of = CNT_W'(DIV_3);
      default:  div_of = '0;
    endcase
  endfunction

`ifdef RATE_CTRL_STEP_EN
  assign step_req = step;
`else
  // Without the step feature the input is ignored and STEP is never entered.
  logic unused_step;
  assign step_req    = 1'b0;
  assign unused_step = step;
`endif

  rate_downcounter #(.CNT_W(CNT_W)) u_cnt (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    tick_d       = 1'b0;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    cnt_load_val = div_of(sel_q);

    case (state_q)
      ST_IDLE: begin
        if (!clear && !stop) begin
          if (start)         state_d = ST_LOAD;
          else if (step_req) state_d = ST_STEP;
        end
      end
      ST_LOAD: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (!clear) begin
          sel_d        = select;
          cnt_load     = 1'b1;
          cnt_load_val = div_of(select);
          state_d      = ST_RUN;
        end
      end
      ST_RUN: begin
        // stop holds the counter; clear (handled below) restarts the period.
        if (stop) begin
          state_d = ST_IDLE;
        end else if (!clear) begin
          if (cnt_zero) begin
            // Period boundary: the only point where a new select takes effect.
            tick_d       = 1'b1;
            sel_d        = select;
            cnt_load     = 1'b1;
            cnt_load_val = div_of(select);
          end else begin
            cnt_dec = 1'b1;
          end
        end
      end
      ST_STEP: begin
        state_d = ST_IDLE;
        tick_d  = !clear;
      end
      default: state_d = ST_IDLE;
    endcase

    // clear restarts the divider from the rate currently in use, in any state.
    if (clear) begin
      cnt_load     = 1'b1;
      cnt_load_val = div_of(sel_q);
    end
  end

  // A held clear yields isolated pulses rather than a continuous level.
  assign clr_d = clear && !clr_out;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      sel_q   <= SEL_EVERY;
      tick    <= 1'b0;
      clr_out <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      tick    <= tick_d;
      clr_out <= clr_d;
    end
  end

  assign running    = (state_q == ST_RUN);
  assign state      = state_q;
  assign active_sel = sel_q;

endmodule

// File: tb/tb_rate_controller.sv
module tb_rate_controller;

  localparam int EV_TICK = 0;
  localparam int EV_CLR  = 1;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  logic       start   = 1'b0;
  logic       stop    = 1'b0;
  logic       step    = 1'b0;
  logic       clear   = 1'b0;
  logic [1:0] select  = 2'b00;
  logic       tick, clr_out, running;
  logic [1:0] state, active_sel;

  int cyc   = 0;
  int tests = 0;
  int fails = 0;

  typedef struct {
    int kind;
    int at;
  } ev_t;
  ev_t exp_q[$];

  rate_controller #(
    .CNT_W (28),
    .DIV_1 (2),
    .DIV_2 (4),
    .DIV_3 (6)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .stop       (stop),
    .step       (step),
    .clear      (clear),
    .select     (select),
    .tick       (tick),
    .clr_out    (clr_out),
    .running    (running),
    .state      (state),
    .active_sel (active_sel)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int at);
    ev_t e;
    e.kind = kind;
    e.at   = at;
    exp_q.push_back(e);
  endtask

  task automatic check_event(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_%s: got pulse at cycle %0d, expected none",
               (kind == EV_TICK) ? "tick" : "clr_out", cyc);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", kind, e.kind);
      chk("event_cycle", cyc, e.at);
    end
  endtask

  // Monitor: every output pulse must match the next expected event.
  always @(negedge clock) begin
    if (reset_n) begin
      if (tick)    check_event(EV_TICK);
      if (clr_out) check_event(EV_CLR);
    end
  end

  initial begin
    int c0, c1, c2;

    // Reset values
    repeat (3) @(negedge clock);
    chk("rst_state", state, 0);
    chk("rst_running", running, 0);
    chk("rst_tick", tick, 0);
    chk("rst_clr_out", clr_out, 0);
    chk("rst_active_sel", active_sel, 0);
    reset_n = 1'b1;

    // Start at select 01: LOAD one cycle, then ticks every 3 cycles.
    // Select moves to 11 mid-period: current period ends at 3, later ones are 7.
    @(negedge clock);
    c0 = cyc;
    start  = 1'b1;
    select = 2'b01;
    push(EV_TICK, c0 + 5);
    push(EV_TICK, c0 + 8);
    push(EV_TICK, c0 + 15);
    push(EV_TICK, c0 + 22);
    @(negedge clock);
    start = 1'b0;
    chk("load_state", state, 1);
    @(negedge clock);
    chk("run_running", running, 1);
    chk("run_state", state, 2);
    chk("run_active_sel", active_sel, 1);
    repeat (4) @(negedge clock);
    select = 2'b11;
    repeat (2) @(negedge clock);
    chk("sel_switch_active_sel", active_sel, 3);

    // stop + clear in the same cycle: clr_out pulse, IDLE, no tick.
    repeat (16) @(negedge clock);
    stop  = 1'b1;
    clear = 1'b1;
    push(EV_CLR, c0 + 25);
    @(negedge clock);
    stop  = 1'b0;
    clear = 1'b0;
    chk("stopclr_state", state, 0);
    chk("stopclr_running", running, 0);
    repeat (5) @(negedge clock);

    // Single step from IDLE.
    c1 = cyc;
    step = 1'b1;
`ifdef RATE_CTRL_STEP_EN
    push(EV_TICK, c1 + 2);
`endif
    @(negedge clock);
    step = 1'b0;
`ifdef RATE_CTRL_STEP_EN
    chk("step_state", state, 3);
`else
    chk("step_ignored_state", state, 0);
`endif
    @(negedge clock);
    chk("after_step_state", state, 0);
    repeat (4) @(negedge clock);

    // select 00: tick every cycle from the cycle after LOAD; reset kills it at once.
    c2 = cyc;
    select = 2'b00;
    start  = 1'b1;
    for (int k = 3; k <= 7; k++) push(EV_TICK, c2 + k);
    @(negedge clock);
    start = 1'b0;
    repeat (6) @(negedge clock);
    #1 reset_n = 1'b0;
    #1;
    chk("async_rst_tick", tick, 0);
    chk("async_rst_state", state, 0);
    chk("async_rst_running", running, 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
    chk("post_rst_state", state, 0);
    chk("post_rst_running", running, 0);

    chk("pending_events", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rate_controller.md
RATE_CONTROLLER -- requirements
Module: rate_controller

Interface
REQ-001 SHALL have parameter CNT_W, default 28, divider counter width.
REQ-002 SHALL have parameter DIV_1, default 4999999, reload value for select 01 (tick period DIV_1+1 cycles).
REQ-003 SHALL have parameter DIV_2, default 99999999, reload value for select 10.
REQ-004 SHALL have parameter DIV_3, default 199999999, reload value for select 11.
REQ-005 SHALL have port clock  input  1  single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port start  input  1  begin ticking (level-sampled each cycle).
REQ-008 SHALL have port stop  input  1  halt ticking.
REQ-009 SHALL have port step  input  1  issue one tick while idle.
REQ-010 SHALL have port clear  input  1  restart divider; request display-counter clear.
REQ-011 SHALL have port select  input  2  requested rate: 00 every cycle, 01/10/11 DIV_1/2/3.
REQ-012 SHALL have port tick  output  1  one-cycle enable pulse to the display counter.
REQ-013 SHALL have port clr_out  output  1  one-cycle par_load pulse to the display counter.
REQ-014 SHALL have port running  output  1  high in RUN.
REQ-015 SHALL have port state  output  2  current FSM state.
REQ-016 SHALL have port active_sel  output  2  rate currently in use.

Function
REQ-017 FSM states SHALL be IDLE=00, LOAD=01, RUN=10, STEP=11.
REQ-018 Command priority SHALL be clear > stop > start > step when asserted in the same cycle.
REQ-019 IDLE: start -> LOAD; step -> STEP; otherwise hold; tick=0.
REQ-020 LOAD (one cycle): latch select into active_sel, reload counter from active divisor (0 for 00), -> RUN; tick=0.
REQ-021 RUN: counter decrements per cycle; at count 0 tick=1 that cycle and counter reloads from select sampled that cycle (select changes take effect only at tick boundaries), active_sel updated.
REQ-022 RUN with active_sel=00 SHALL assert tick every cycle; first tick one cycle after LOAD.
REQ-023 stop in RUN -> IDLE next cycle; tick suppressed in the stop cycle; counter value held.
REQ-024 start in RUN SHALL be ignored.
REQ-025 STEP (one cycle): tick=1, -> IDLE; counter untouched.
REQ-026 clear in any state: clr_out=1 next cycle, counter reloaded from current active_sel, tick suppressed that cycle; state unchanged except STEP, which goes to IDLE without ticking.
REQ-027 Counter arithmetic SHALL be CNT_W-bit unsigned; no underflow below 0 (reload instead).
REQ-028 tick and clr_out SHALL be registered, never asserted for two consecutive cycles except tick at select 00.

Reset
REQ-029 reset_n low SHALL immediately force state=IDLE, counter=0, active_sel=00, tick=0, clr_out=0, running=0.
REQ-030 Reset mid-RUN SHALL discard any pending tick; after release the block stays IDLE until start.

Configuration
REQ-031 With RATE_CTRL_STEP_EN defined, STEP state and step input SHALL behave per REQ-019/REQ-025.
REQ-032 Without RATE_CTRL_STEP_EN, step SHALL be ignored, STEP encoding unreachable, state never 11.

Structure
REQ-033 Package rate_ctrl_pkg SHALL hold the state encoding typedef and select encoding constants.
REQ-034 Sub-module rate_downcounter SHALL implement the loadable CNT_W down-counter with zero flag.

Verification (override DIV_1=2, DIV_2=4, DIV_3=6)
REQ-035 Reset, start with select=01 -> LOAD 1 cycle, then tick every 3 cycles; running=1.
REQ-036 RUN at select=01, change select to 11 mid-period -> current period completes at 3, following periods 7 cycles.
REQ-037 RUN, stop and clear same cycle -> clr_out=1, state IDLE next cycle, no tick.
REQ-038 IDLE, step (macro on) -> exactly one tick, state 11 for one cycle; macro off -> no tick, state stays 00.
REQ-039 select=00, start -> tick continuous from cycle after LOAD; reset_n low mid-run -> tick=0 immediately, state 00.
